// File: rtl/sap_controller_sequencer.sv
// SAP-1 control sequencer: falling-edge one-hot T-state ring plus Moore control-word decode.
// Optional SAP_VAR_CYCLE_EN: instructions return to T1 right after their last active state.
module sap_controller_sequencer (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [3:0] opcode,
  output logic [5:0] t_state,
  output logic       pc_out_en,
  output logic       pc_inc,
  output logic       mar_load,
  output logic       ram_out_en,
  output logic       ir_load,
  output logic       ir_out_en,
  output logic       a_load,
  output logic       a_out_en,
  output logic       b_load,
  output logic       alu_sub,
  output logic       alu_out_en,
  output logic       out_load,
  output logic       halt
);

  localparam int unsigned T_W  = 6;
  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_LDA = OP_W'(4'b0000);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(4'b0001);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(4'b0010);
  localparam logic [OP_W-1:0] OP_OUT = OP_W'(4'b1110);
  localparam logic [OP_W-1:0] OP_HLT = OP_W'(4'b1111);

  typedef enum logic [T_W-1:0] {
    T1 = T_W'(6'b000001),
    T2 = T_W'(6'b000010),
    T3 = T_W'(6'b000100),
    T4 = T_W'(6'b001000),
    T5 = T_W'(6'b010000),
    T6 = T_W'(6'b100000)
  } t_state_e;

  t_state_e state_q;
  t_state_e state_d;

  logic op_lda;
  logic op_add;
  logic op_sub;
  logic op_out;
  logic op_hlt;
  logic op_alu;

  assign op_lda = (opcode == OP_LDA);
  assign op_add = (opcode == OP_ADD);
  assign op_sub = (opcode == OP_SUB);
  assign op_out = (opcode == OP_OUT);
  assign op_hlt = (opcode == OP_HLT);
  assign op_alu = op_add | op_sub;

  // Ring register advances on the falling edge so controls settle before the datapath's rising edge.
  always_ff @(negedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= T1;
    end else begin
      state_q <= state_d;
    end
  end

  // Next ring state: rotate left, freeze at T4 on HLT, optional early return to T1.
  always_comb begin
    state_d = T1;
    unique case (state_q)
      T1: state_d = T2;
      T2: state_d = T3;
      T3: state_d = T4;
      T4: begin
        if (op_hlt) begin
          state_d = T4;
        end else begin
`ifdef SAP_VAR_CYCLE_EN
          state_d = (op_lda || op_alu) ? T5 : T1;
`else
          state_d = T5;
`endif
        end
      end
      T5: begin
`ifdef SAP_VAR_CYCLE_EN
        state_d = op_alu ? T6 : T1;
`else
        state_d = T6;
`endif
      end
      T6: state_d = T1;
      default: state_d = T1;
    endcase
  end

  // Control word decode from the current T-state and opcode.
  always_comb begin
    pc_out_en  = 1'b0;
    pc_inc     = 1'b0;
    mar_load   = 1'b0;
    ram_out_en = 1'b0;
    ir_load    = 1'b0;
    ir_out_en  = 1'b0;
    a_load     = 1'b0;
    a_out_en   = 1'b0;
    b_load     = 1'b0;
    alu_sub    = 1'b0;
    alu_out_en = 1'b0;
    out_load   = 1'b0;
    halt       = 1'b0;
    unique case (state_q)
      T1: begin
        pc_out_en = 1'b1;
        mar_load  = 1'b1;
      end
      T2: pc_inc = 1'b1;
      T3: begin
        ram_out_en = 1'b1;
        ir_load    = 1'b1;
      end
      T4: begin
        if (op_lda || op_alu) begin
          ir_out_en = 1'b1;
          mar_load  = 1'b1;
        end else if (op_out) begin
          a_out_en = 1'b1;
          out_load = 1'b1;
        end else if (op_hlt) begin
          halt = 1'b1;
        end
      end
      T5: begin
        if (op_lda) begin
          ram_out_en = 1'b1;
          a_load     = 1'b1;
        end else if (op_alu) begin
          ram_out_en = 1'b1;
          b_load     = 1'b1;
          alu_sub    = op_sub;
        end
      end
      T6: begin
        if (op_alu) begin
          alu_out_en = 1'b1;
          a_load     = 1'b1;
          alu_sub    = op_sub;
        end
      end
      default: ;
    endcase
  end

  assign t_state = state_q;

endmodule

// File: tb/tb_sap_controller_sequencer.sv
// Directed bench for sap_controller_sequencer: vector table for instruction sequences plus HLT, async reset and bus-driver sweeps.
module tb_sap_controller_sequencer;

  logic       clk;
  logic       clr_n;
  logic [3:0] opcode;
  logic [5:0] t_state;
  logic pc_out_en, pc_inc, mar_load, ram_out_en, ir_load, ir_out_en;
  logic a_load, a_out_en, b_load, alu_sub, alu_out_en, out_load, halt;

  sap_controller_sequencer dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .opcode     (opcode),
    .t_state    (t_state),
    .pc_out_en  (pc_out_en),
    .pc_inc     (pc_inc),
    .mar_load   (mar_load),
    .ram_out_en (ram_out_en),
    .ir_load    (ir_load),
    .ir_out_en  (ir_out_en),
    .a_load     (a_load),
    .a_out_en   (a_out_en),
    .b_load     (b_load),
    .alu_sub    (alu_sub),
    .alu_out_en (alu_out_en),
    .out_load   (out_load),
    .halt       (halt)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  localparam logic [12:0] PCO  = 13'h1000;
  localparam logic [12:0] PCI  = 13'h0800;
  localparam logic [12:0] MAR  = 13'h0400;
  localparam logic [12:0] RAMO = 13'h0200;
  localparam logic [12:0] IRL  = 13'h0100;
  localparam logic [12:0] IRO  = 13'h0080;
  localparam logic [12:0] AL   = 13'h0040;
  localparam logic [12:0] AO   = 13'h0020;
  localparam logic [12:0] BL   = 13'h0010;
  localparam logic [12:0] SUB  = 13'h0008;
  localparam logic [12:0] ALUO = 13'h0004;
  localparam logic [12:0] OUTL = 13'h0002;
  localparam logic [12:0] HLT  = 13'h0001;

  typedef struct {
    logic [3:0]  op;
    logic [5:0]  t;
    logic [12:0] ctrl;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [12:0] ctrl;
  assign ctrl = {pc_out_en, pc_inc, mar_load, ram_out_en, ir_load, ir_out_en,
                 a_load, a_out_en, b_load, alu_sub, alu_out_en, out_load, halt};

  function automatic void add(input logic [3:0] op, input logic [5:0] t, input logic [12:0] c);
    vec_t v;
    v.op = op; v.t = t; v.ctrl = c;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Assert reset between edges, release shortly after a rising edge.
  task automatic do_reset();
    clr_n = 1'b0;
    @(posedge clk);
    #2 clr_n = 1'b1;
  endtask

  task automatic add_fetch(input logic [3:0] op);
    add(op, 6'b000001, PCO | MAR);
    add(op, 6'b000010, PCI);
    add(op, 6'b000100, RAMO | IRL);
  endtask

  int drivers;

  initial begin
    opcode = 4'b0000;
    clr_n  = 1'b0;
    repeat (2) @(posedge clk);

    // LDA
    add_fetch(4'b0000);
    add(4'b0000, 6'b001000, IRO | MAR);
    add(4'b0000, 6'b010000, RAMO | AL);
`ifndef SAP_VAR_CYCLE_EN
    add(4'b0000, 6'b100000, 13'h0);
`endif
    // ADD
    add_fetch(4'b0001);
    add(4'b0001, 6'b001000, IRO | MAR);
    add(4'b0001, 6'b010000, RAMO | BL);
    add(4'b0001, 6'b100000, ALUO | AL);
    // SUB
    add_fetch(4'b0010);
    add(4'b0010, 6'b001000, IRO | MAR);
    add(4'b0010, 6'b010000, RAMO | BL | SUB);
    add(4'b0010, 6'b100000, ALUO | AL | SUB);
    // OUT
    add_fetch(4'b1110);
    add(4'b1110, 6'b001000, AO | OUTL);
`ifndef SAP_VAR_CYCLE_EN
    add(4'b1110, 6'b010000, 13'h0);
    add(4'b1110, 6'b100000, 13'h0);
`endif
    // undefined opcode
    add_fetch(4'b0101);
    add(4'b0101, 6'b001000, 13'h0);
`ifndef SAP_VAR_CYCLE_EN
    add(4'b0101, 6'b010000, 13'h0);
    add(4'b0101, 6'b100000, 13'h0);
`endif
    // HLT
    add_fetch(4'b1111);
    add(4'b1111, 6'b001000, HLT);

    do_reset();
    foreach (vecs[i]) begin
      opcode = vecs[i].op;
      #1;
      check($sformatf("vec%0d t_state", i), 16'(t_state), 16'(vecs[i].t));
      check($sformatf("vec%0d ctrl", i), 16'(ctrl), 16'(vecs[i].ctrl));
      if (i != vecs.size() - 1) begin
        @(negedge clk);
        @(posedge clk);
      end
    end

    // HLT freezes the ring at T4
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      @(posedge clk);
      #1;
      check("hlt_hold t_state", 16'(t_state), 16'h0008);
      check("hlt_hold ctrl", 16'(ctrl), 16'(HLT));
    end
    clr_n = 1'b0;
    #1;
    check("hlt_clr t_state", 16'(t_state), 16'h0001);
    check("hlt_clr halt", 16'(halt), 16'h0000);
    @(posedge clk);
    #2 clr_n = 1'b1;

    // Async reset during LDA T5
    opcode = 4'b0000;
    do_reset();
    repeat (4) @(negedge clk);
    #2;
    check("lda_t5 t_state", 16'(t_state), 16'h0010);
    clr_n = 1'b0;
    #1;
    check("async_rst t_state", 16'(t_state), 16'h0001);
    check("async_rst a_load", 16'(a_load), 16'h0000);
    @(posedge clk);
    #1;
    check("async_rst edge a_load", 16'(a_load), 16'h0000);
    check("async_rst edge ctrl", 16'(ctrl), 16'(PCO | MAR));
    #1 clr_n = 1'b1;

    // Every opcode: one-hot ring and at most one bus driver
    for (int op = 0; op < 16; op++) begin
      opcode = 4'(op);
      do_reset();
      for (int s = 0; s < 8; s++) begin
        #1;
        drivers = int'(pc_out_en) + int'(ram_out_en) + int'(ir_out_en) +
                  int'(a_out_en) + int'(alu_out_en);
        check($sformatf("op%0d s%0d onehot", op, s), 16'($onehot(t_state)), 16'h0001);
        check($sformatf("op%0d s%0d bus", op, s), 16'(drivers <= 1), 16'h0001);
        @(negedge clk);
        @(posedge clk);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
